// File: rtl/seg7_display_scan.sv
// Time-multiplexed hex seven-segment driver. Scans one digit per TICKS_PER_DIGIT
// scan ticks and swaps in newly loaded values only at frame boundaries.
module seg7_display_scan #(
  parameter int DIGITS          = 8,
  parameter int TICKS_PER_DIGIT = 1,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk_100mhz,
  input  logic                rst,
  input  logic                scan_tick,
  input  logic [4*DIGITS-1:0] value_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                value_load,
  input  logic                blank_lead,
  output logic [DIGITS-1:0]   an_out,
  output logic [6:0]          seg_out,
  output logic                dp_out,
  output logic                frame_done,
  output logic                pending
);

  localparam int              IDXW       = $clog2(DIGITS);
  localparam bit              INV        = (ACTIVE_LOW != 0);
  localparam logic [7:0]      DWELL_LAST = 8'(TICKS_PER_DIGIT - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{INV}};
  localparam logic [6:0]      SEG_OFF    = {7{INV}};

  logic [7:0]          dwell_q, dwell_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] shadowVal_q, shadowVal_d;
  logic [DIGITS-1:0]   shadowDp_q, shadowDp_d;
  logic [4*DIGITS-1:0] dispVal_q, dispVal_d;
  logic [DIGITS-1:0]   dispDp_q, dispDp_d;
  logic                pending_q, pending_d;
  logic                frameDone_q, frameDone_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                tickLast;
  logic                wrap;
  logic [DIGITS-1:0]   zeroAbove;
  logic [3:0]          curNibble;
  logic                curBlank;
  logic [DIGITS-1:0]   anHigh;

  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    case (nib)
      4'h0:    hexToSeg = 7'h3F;
      4'h1:    hexToSeg = 7'h06;
      4'h2:    hexToSeg = 7'h5B;
      4'h3:    hexToSeg = 7'h4F;
      4'h4:    hexToSeg = 7'h66;
      4'h5:    hexToSeg = 7'h6D;
      4'h6:    hexToSeg = 7'h7D;
      4'h7:    hexToSeg = 7'h07;
      4'h8:    hexToSeg = 7'h7F;
      4'h9:    hexToSeg = 7'h6F;
      4'hA:    hexToSeg = 7'h77;
      4'hB:    hexToSeg = 7'h7C;
      4'hC:    hexToSeg = 7'h39;
      4'hD:    hexToSeg = 7'h5E;
      4'hE:    hexToSeg = 7'h79;
      default: hexToSeg = 7'h71;
    endcase
  endfunction

  assign tickLast = scan_tick && (dwell_q == DWELL_LAST);
  assign wrap     = tickLast && (idx_q == IDX_LAST);

  // zeroAbove[k] is set when every nibble from k up to the top digit is zero
  always_comb begin
    zeroAbove = '0;
    for (int k = 0; k < DIGITS; k++) begin
      zeroAbove[k] = ((dispVal_q >> (4 * k)) == '0);
    end
  end

  always_comb begin
    curNibble = dispVal_q[{idx_q, 2'b00} +: 4];
    curBlank  = blank_lead && (idx_q != '0) && zeroAbove[idx_q];
    anHigh    = '0;
    anHigh[idx_q] = 1'b1;
  end

  always_comb begin
    dwell_d     = dwell_q;
    idx_d       = idx_q;
    shadowVal_d = shadowVal_q;
    shadowDp_d  = shadowDp_q;
    dispVal_d   = dispVal_q;
    dispDp_d    = dispDp_q;
    pending_d   = pending_q;
    frameDone_d = wrap;

    if (scan_tick) begin
      if (tickLast) begin
        dwell_d = '0;
        idx_d   = wrap ? '0 : idx_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 8'd1;
      end
    end

    // A load on the wrap cycle bypasses the shadow and commits straight away
    if (wrap) begin
      pending_d = 1'b0;
      if (value_load) begin
        dispVal_d = value_in;
        dispDp_d  = dp_in;
      end else if (pending_q) begin
        dispVal_d = shadowVal_q;
        dispDp_d  = shadowDp_q;
      end
    end else if (value_load) begin
      shadowVal_d = value_in;
      shadowDp_d  = dp_in;
      pending_d   = 1'b1;
    end

    an_d  = INV ? ~anHigh : anHigh;
    seg_d = curBlank ? SEG_OFF : (INV ? ~hexToSeg(curNibble) : hexToSeg(curNibble));
    dp_d  = INV ? ~dispDp_q[idx_q] : dispDp_q[idx_q];
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      dwell_q     <= '0;
      idx_q       <= '0;
      shadowVal_q <= '0;
      shadowDp_q  <= '0;
      dispVal_q   <= '0;
      dispDp_q    <= '0;
      pending_q   <= 1'b0;
      frameDone_q <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= INV;
    end else begin
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      shadowVal_q <= shadowVal_d;
      shadowDp_q  <= shadowDp_d;
      dispVal_q   <= dispVal_d;
      dispDp_q    <= dispDp_d;
      pending_q   <= pending_d;
      frameDone_q <= frameDone_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign frame_done = frameDone_q;
  assign pending    = pending_q;

endmodule
